// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with byte strobe, line-idle flag and end-of-packet pulse
//   CLK      in   system clock, rising edge
//   RSTN     in   asynchronous active-low reset
//   rx       in   raw serial line, idle high, asynchronous to CLK
//   rx_ready out  one-CLK strobe, new byte on rx_data
//   rx_data  out  last correctly framed byte, held until the next one
//   rx_idle  out  line has been mark for at least IDLE_BITS bit times
//   rx_eop   out  one-CLK pulse when rx_idle rises after at least one byte
module uart_rx #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       rx,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_idle,
  output logic       rx_eop
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int CW   = $clog2(CPB);
  localparam int ILIM = IDLE_BITS * CPB;
  localparam int IW   = $clog2(ILIM + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0] ILIM_V  = IW'(ILIM);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            idle_q, idle_d;
  logic            eop_q, eop_d;
  logic            seen_q, seen_d;
  logic [IW-1:0]   icnt_q, icnt_d;
  logic            rxs;
  assign rxs = sync_q[1];
  always_comb begin
    sync_d  = {sync_q[0], rx};
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    seen_d  = seen_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt_q == CPB_M1) begin
        cnt_d          = '0;
        shift_d[bit_q] = rxs;
        bit_d          = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == CPB_M1) begin
        cnt_d   = '0;
        state_d = rxs ? IDLE : BRK;
        data_d  = rxs ? shift_q : data_q;
        ready_d = rxs;
        seen_d  = seen_q | rxs;
      end
      BRK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    icnt_d = (state_q == IDLE && rxs) ? ((icnt_q == ILIM_V) ? icnt_q : icnt_q + 1'b1) : '0;
    idle_d = (state_d != IDLE) ? 1'b0 : (idle_q | (icnt_d == ILIM_V));
    eop_d  = idle_d & ~idle_q & seen_q;
    if (eop_d) seen_d = 1'b0;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      idle_q  <= 1'b1;
      eop_q   <= 1'b0;
      seen_q  <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
      eop_q   <= eop_d;
      seen_q  <= seen_d;
      icnt_q  <= icnt_d;
    end
  end
  assign rx_ready = ready_q;
  assign rx_data  = data_q;
  assign rx_idle  = idle_q;
  assign rx_eop   = eop_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 104;
  logic       CLK = 1'b0;
  logic       RSTN;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_idle;
  logic       rx_eop;
  int vec = 0;
  int errs = 0;
  int rdy_cnt = 0;
  int eop_cnt = 0;
  int rdy_wide = 0;
  int eop_wide = 0;
  logic rdy_prev = 1'b0;
  logic eop_prev = 1'b0;
  uart_rx dut (
    .CLK(CLK), .RSTN(RSTN), .rx(rx),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_idle(rx_idle), .rx_eop(rx_eop)
  );
  always #42 CLK = ~CLK;
  always @(negedge CLK) begin
    if (rx_ready) rdy_cnt <= rdy_cnt + 1;
    if (rx_ready && rdy_prev) rdy_wide <= rdy_wide + 1;
    if (rx_eop) eop_cnt <= eop_cnt + 1;
    if (rx_eop && eop_prev) eop_wide <= eop_wide + 1;
    rdy_prev <= rx_ready;
    eop_prev <= rx_eop;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic bit_time(input logic v, input int n);
    rx = v;
    repeat (n * CPB) @(negedge CLK);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(b[i], 1);
    bit_time(stop, 1);
  endtask
  initial begin
    rx = 1'b0;
    RSTN = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_ready", rx_ready, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_idle", rx_idle, 1);
    chk("rst_eop", rx_eop, 0);
    RSTN = 1'b1;
    send(8'h48, 1'b1);
    chk("h_cnt", rdy_cnt, 1);
    chk("h_data", rx_data, 8'h48);
    chk("h_idle", rx_idle, 0);
    send(8'h65, 1'b1);
    chk("e_cnt", rdy_cnt, 2);
    chk("e_data", rx_data, 8'h65);
    chk("e_idle", rx_idle, 0);
    bit_time(1'b1, 15);
    chk("pre_idle", rx_idle, 0);
    chk("pre_eop", eop_cnt, 0);
    bit_time(1'b1, 2);
    chk("idle_up", rx_idle, 1);
    chk("eop_once", eop_cnt, 1);
    bit_time(1'b1, 20);
    chk("eop_hold", eop_cnt, 1);
    rx = 1'b0;
    repeat (20) @(negedge CLK);
    rx = 1'b1;
    repeat (100) @(negedge CLK);
    chk("gl_idle_drop", rx_idle, 0);
    chk("gl_cnt", rdy_cnt, 2);
    chk("gl_data", rx_data, 8'h65);
    bit_time(1'b1, 17);
    chk("gl_idle_back", rx_idle, 1);
    chk("gl_no_eop", eop_cnt, 1);
    send(8'h3C, 1'b0);
    bit_time(1'b0, 3);
    chk("fe_cnt", rdy_cnt, 2);
    chk("fe_data", rx_data, 8'h65);
    bit_time(1'b1, 1);
    send(8'hA5, 1'b1);
    chk("a5_cnt", rdy_cnt, 3);
    chk("a5_data", rx_data, 8'hA5);
    bit_time(1'b1, 17);
    chk("a5_eop", eop_cnt, 2);
    bit_time(1'b0, 1);
    bit_time(1'b1, 1);
    bit_time(1'b0, 1);
    rx = 1'b1;
    repeat (30) @(negedge CLK);
    #10 RSTN = 1'b0;
    #1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_ready", rx_ready, 0);
    chk("mid_rst_idle", rx_idle, 1);
    chk("mid_rst_eop", rx_eop, 0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    bit_time(1'b1, 2);
    chk("post_rst_eop", eop_cnt, 2);
    send(8'h81, 1'b1);
    chk("post_rst_cnt", rdy_cnt, 4);
    chk("post_rst_data", rx_data, 8'h81);
    chk("ready_width", rdy_wide, 0);
    chk("eop_width", eop_wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
